// File: rtl/universal_rotate_reg.sv
// Parametrised rotate/shift register with serial-in shifts and multi-step rotate-by-N (busy/done).
// Optional feature macro: UROT_PARITY_EN enables the combinational parity output.
module universal_rotate_reg #(
   parameter int WIDTH = 8,
   parameter int AMT_W = $clog2(WIDTH)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data,
   input  logic [2:0]       sel,
   input  logic [AMT_W-1:0] amt,
   input  logic             sin,
   output logic [WIDTH-1:0] qout,
   output logic             msb_out,
   output logic             lsb_out,
   output logic             busy,
   output logic             done,
   output logic             parity
);

   typedef enum logic {IDLE, ROT} state_t;

   state_t           state;
   logic             dir_left;
   logic [AMT_W-1:0] cnt;

   function automatic logic [WIDTH-1:0] ror1(input logic [WIDTH-1:0] v);
      return {v[0], v[WIDTH-1:1]};
   endfunction

   function automatic logic [WIDTH-1:0] rol1(input logic [WIDTH-1:0] v);
      return {v[WIDTH-2:0], v[WIDTH-1]};
   endfunction

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         qout     <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         cnt      <= '0;
         dir_left <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               case (sel)
                  3'd1: qout <= ror1(qout);
                  3'd2: qout <= rol1(qout);
                  3'd3: qout <= data;
                  3'd4: qout <= {sin, qout[WIDTH-1:1]};
                  3'd5: qout <= {qout[WIDTH-2:0], sin};
                  3'd6, 3'd7: begin
                     // accept edge only latches the op; stepping starts on the next edge
                     dir_left <= sel[0];
                     cnt      <= amt;
                     if (amt == '0) begin
                        done <= 1'b1;
                     end else begin
                        busy  <= 1'b1;
                        state <= ROT;
                     end
                  end
                  default: begin
                  end
               endcase
            end
            ROT: begin
               qout <= dir_left ? rol1(qout) : ror1(qout);
               cnt  <= cnt - AMT_W'(1);
               if (cnt == AMT_W'(1)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign msb_out = qout[WIDTH-1];
   assign lsb_out = qout[0];

`ifdef UROT_PARITY_EN
   assign parity = ^qout;
`else
   assign parity = 1'b0;
`endif

endmodule

// File: tb/tb_universal_rotate_reg.sv
// Randomised self-checking bench for universal_rotate_reg (WIDTH=8) against a step-count reference model.
module tb_universal_rotate_reg;
   localparam int W = 8;
   localparam int AW = 3;

   logic          clock = 1'b0;
   logic          reset;
   logic [W-1:0]  data;
   logic [2:0]    sel;
   logic [AW-1:0] amt;
   logic          sin;
   logic [W-1:0]  qout;
   logic          msb_out, lsb_out, busy, done, parity;

   int vectors = 0;
   int miscompares = 0;

   // reference model state: a multi-step op is described by base value, total and taken steps
   logic [W-1:0] m_q;
   bit           m_busy, m_done, m_left;
   logic [W-1:0] m_base;
   int           m_total, m_taken;

   universal_rotate_reg #(.WIDTH(W), .AMT_W(AW)) dut (
      .clock(clock), .reset(reset), .data(data), .sel(sel), .amt(amt), .sin(sin),
      .qout(qout), .msb_out(msb_out), .lsb_out(lsb_out), .busy(busy), .done(done),
      .parity(parity)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic logic [W-1:0] rot(input logic [W-1:0] v, input int n, input bit left);
      logic [2*W-1:0] d;
      logic [W-1:0]   r;
      d = {v, v};
      if (left) begin
         d = d << n;
         r = d[2*W-1:W];
      end else begin
         d = d >> n;
         r = d[W-1:0];
      end
      return r;
   endfunction

   function automatic bit par(input logic [W-1:0] v);
      int c = 0;
      for (int i = 0; i < W; i++) if (v[i]) c++;
`ifdef UROT_PARITY_EN
      return bit'(c % 2);
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_edge();
      if (reset) begin
         m_q = '0; m_busy = 0; m_done = 0;
      end else if (m_busy) begin
         m_done = 0;
         m_taken++;
         m_q = rot(m_base, m_taken % W, m_left);
         if (m_taken == m_total) begin
            m_busy = 0;
            m_done = 1;
         end
      end else begin
         m_done = 0;
         case (sel)
            3'd1: m_q = rot(m_q, 1, 0);
            3'd2: m_q = rot(m_q, 1, 1);
            3'd3: m_q = data;
            3'd4: m_q = (m_q >> 1) | (W'(sin) << (W - 1));
            3'd5: m_q = (m_q << 1) | W'(sin);
            3'd6, 3'd7: begin
               m_base = m_q; m_total = int'(amt); m_taken = 0; m_left = (sel == 3'd7);
               if (m_total == 0) m_done = 1;
               else m_busy = 1;
            end
            default: ;
         endcase
      end
   endtask

   task automatic tick();
      @(posedge clock);
      model_edge();
      #1;
      check("qout", 32'(qout), 32'(m_q));
      check("msb_out", 32'(msb_out), 32'(m_q[W-1]));
      check("lsb_out", 32'(lsb_out), 32'(m_q[0]));
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("parity", 32'(parity), 32'(par(m_q)));
   endtask

   task automatic drive(input bit r, input logic [2:0] s, input logic [W-1:0] d,
                        input logic [AW-1:0] a, input logic si);
      reset = r; sel = s; data = d; amt = a; sin = si;
      tick();
   endtask

   initial begin
      m_q = '0; m_busy = 0; m_done = 0; m_left = 0; m_base = '0; m_total = 0; m_taken = 0;
      reset = 1; sel = 3'd3; data = 8'hFF; amt = '0; sin = 0;
      // reset for two cycles while a load is requested
      drive(1, 3'd3, 8'hFF, 0, 0);
      drive(1, 3'd3, 8'hFF, 0, 0);
      check("reset_q", 32'(qout), 32'h00);

      drive(0, 3'd3, 8'hA5, 0, 0);
      drive(0, 3'd1, 8'h00, 0, 0);
      check("ror1_const", 32'(qout), 32'hD2);
      drive(0, 3'd3, 8'hA5, 0, 0);
      drive(0, 3'd2, 8'h00, 0, 0);
      check("rol1_const", 32'(qout), 32'h4B);
      drive(0, 3'd3, 8'h0F, 0, 0);
      drive(0, 3'd4, 8'h00, 0, 1);
      check("shr_const", 32'(qout), 32'h87);
      drive(0, 3'd3, 8'h81, 0, 0);
      drive(0, 3'd5, 8'h00, 0, 0);
      check("shl_const", 32'(qout), 32'h02);

      // rolN by 3 with a load attempted while busy
      drive(0, 3'd3, 8'h01, 0, 0);
      drive(0, 3'd7, 8'h00, 3, 0);
      check("rolN_busy", 32'(busy), 32'h1);
      drive(0, 3'd3, 8'hEE, 5, 1);
      drive(0, 3'd3, 8'hEE, 5, 1);
      drive(0, 3'd0, 8'h00, 0, 0);
      check("rolN_final", 32'(qout), 32'h08);
      check("rolN_done", 32'(done), 32'h1);
      drive(0, 3'd0, 8'h00, 0, 0);
      check("done_clears", 32'(done), 32'h0);

      // zero-step rotate
      drive(0, 3'd3, 8'h80, 0, 0);
      drive(0, 3'd6, 8'h00, 0, 0);
      check("amt0_q", 32'(qout), 32'h80);
      drive(0, 3'd0, 8'h00, 0, 0);

      // reset aborts a long rotate
      drive(0, 3'd3, 8'h01, 0, 0);
      drive(0, 3'd6, 8'h00, 7, 0);
      drive(0, 3'd0, 8'h00, 0, 0);
      drive(0, 3'd0, 8'h00, 0, 0);
      drive(1, 3'd0, 8'h00, 0, 0);
      drive(0, 3'd0, 8'h00, 0, 0);
      check("abort_no_done", 32'(done), 32'h0);
      drive(0, 3'd3, 8'h07, 0, 0);

      // randomised traffic, occasional reset
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(0, 99) < 2), 3'($urandom_range(0, 7)), W'($urandom),
               AW'($urandom), 1'($urandom));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
